// File: rtl/cp0_pkg.sv
// ============================================================================
// Module      : cp0_pkg
// Description : CP0 register numbers, exception type codes, ExcCode values,
//               Status/Cause bit positions and the exception decoder.
//               Honours the CP0_BADVADDR_EN build option.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cp0_pkg;

  localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_REG_EPC      = 5'd14;
  localparam logic [4:0] CP0_REG_PRID     = 5'd15;
  localparam logic [4:0] CP0_REG_CONFIG   = 5'd16;

  localparam logic [31:0] EXC_TYPE_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_TYPE_ADEL    = 32'h0000_0004;
  localparam logic [31:0] EXC_TYPE_ADES    = 32'h0000_0005;
  localparam logic [31:0] EXC_TYPE_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_TYPE_RI      = 32'h0000_000a;
  localparam logic [31:0] EXC_TYPE_OV      = 32'h0000_000c;
  localparam logic [31:0] EXC_TYPE_TRAP    = 32'h0000_000d;
  localparam logic [31:0] EXC_TYPE_ERET    = 32'h0000_000e;

  localparam logic [4:0] EXCCODE_INT  = 5'h00;
  localparam logic [4:0] EXCCODE_ADEL = 5'h04;
  localparam logic [4:0] EXCCODE_ADES = 5'h05;
  localparam logic [4:0] EXCCODE_SYS  = 5'h08;
  localparam logic [4:0] EXCCODE_RI   = 5'h0a;
  localparam logic [4:0] EXCCODE_OV   = 5'h0c;
  localparam logic [4:0] EXCCODE_TR   = 5'h0d;

  localparam int STATUS_EXL     = 1;
  localparam int CAUSE_BD       = 31;
  localparam int CAUSE_EXC_LSB  = 2;
  localparam int CAUSE_EXC_MSB  = 6;
  localparam int CAUSE_IPSW_LSB = 8;
  localparam int CAUSE_IPSW_MSB = 9;
  localparam int CAUSE_IPHW_LSB = 10;
  localparam int CAUSE_IPHW_MSB = 15;

  typedef struct packed {
    logic       take;
    logic       eret;
    logic [4:0] code;
  } exc_decode_t;

  function automatic exc_decode_t decode_except(input logic [31:0] exc_type);
    exc_decode_t d;
    d = '{take: 1'b0, eret: 1'b0, code: 5'h00};
    case (exc_type)
      EXC_TYPE_INT:     begin d.take = 1'b1; d.code = EXCCODE_INT; end
      EXC_TYPE_SYSCALL: begin d.take = 1'b1; d.code = EXCCODE_SYS; end
      EXC_TYPE_RI:      begin d.take = 1'b1; d.code = EXCCODE_RI;  end
      EXC_TYPE_OV:      begin d.take = 1'b1; d.code = EXCCODE_OV;  end
      EXC_TYPE_TRAP:    begin d.take = 1'b1; d.code = EXCCODE_TR;  end
`ifdef CP0_BADVADDR_EN
      EXC_TYPE_ADEL:    begin d.take = 1'b1; d.code = EXCCODE_ADEL; end
      EXC_TYPE_ADES:    begin d.take = 1'b1; d.code = EXCCODE_ADES; end
`endif
      EXC_TYPE_ERET:    d.eret = 1'b1;
      default:          ;
    endcase
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cp0_timer.sv
// ============================================================================
// Module      : cp0_timer
// Description : CP0 Count/Compare pair and the sticky timer interrupt.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        timer_int_q, timer_int_d;

  always_comb begin
    count_d     = count_q + 32'd1;
    compare_d   = compare_q;
    timer_int_d = timer_int_q;
    if (compare_q != 32'd0 && count_q == compare_q) timer_int_d = 1'b1;
    if (we_i && waddr_i == CP0_REG_COUNT) count_d = data_i;
    // A Compare write acknowledges the interrupt, overriding a same-edge match.
    if (we_i && waddr_i == CP0_REG_COMPARE) begin
      compare_d   = data_i;
      timer_int_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= 32'd0;
      compare_q   <= 32'd0;
      timer_int_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      compare_q   <= compare_d;
      timer_int_q <= timer_int_d;
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_int_o = timer_int_q;

endmodule

`default_nettype wire

// File: rtl/cp0_reg.sv
// ============================================================================
// Module      : cp0_reg
// Description : Coprocessor-0 register file: Status/Cause/EPC, read mux and
//               exception capture; Count/Compare live in cp0_timer.
//               Build option CP0_BADVADDR_EN adds BadVAddr and bad_addr_i.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cp0_reg
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE   = 32'h004c_0102,
  parameter logic [31:0] CONFIG_VALUE = 32'h0000_8000,
  parameter logic [31:0] STATUS_RESET = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] data_o,
  input  logic [5:0]  int_i,
  input  logic [31:0] except_type_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
`ifdef CP0_BADVADDR_EN
  input  logic [31:0] bad_addr_i,
`endif
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  exc_decode_t exc;
`ifdef CP0_BADVADDR_EN
  logic [31:0] badvaddr_q, badvaddr_d;
`endif

  cp0_timer u_timer (
    .clk         (clk),
    .rst         (rst),
    .we_i        (we_i),
    .waddr_i     (waddr_i),
    .data_i      (data_i),
    .count_o     (count_o),
    .compare_o   (compare_o),
    .timer_int_o (timer_int_o)
  );

  always_comb begin
    exc      = decode_except(except_type_i);
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
`ifdef CP0_BADVADDR_EN
    badvaddr_d = badvaddr_q;
`endif
    cause_d[CAUSE_IPHW_MSB:CAUSE_IPHW_LSB] = {int_i[5] | timer_int_o, int_i[4:0]};

    if (we_i) begin
      case (waddr_i)
        CP0_REG_STATUS: status_d = data_i;
        CP0_REG_CAUSE:  cause_d[CAUSE_IPSW_MSB:CAUSE_IPSW_LSB] = data_i[9:8];
        CP0_REG_EPC:    epc_d = data_i;
        default:        ;
      endcase
    end

    // Exception fields are applied after the write so they take precedence.
    if (exc.take) begin
      if (!status_q[STATUS_EXL]) begin
        epc_d             = is_in_delayslot_i ? current_inst_addr_i - 32'd4
                                              : current_inst_addr_i;
        cause_d[CAUSE_BD] = is_in_delayslot_i;
      end
      status_d[STATUS_EXL]                 = 1'b1;
      cause_d[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = exc.code;
`ifdef CP0_BADVADDR_EN
      if (except_type_i == EXC_TYPE_ADEL || except_type_i == EXC_TYPE_ADES)
        badvaddr_d = bad_addr_i;
`endif
    end else if (exc.eret) begin
      status_d[STATUS_EXL] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= STATUS_RESET;
      cause_q  <= 32'd0;
      epc_q    <= 32'd0;
`ifdef CP0_BADVADDR_EN
      badvaddr_q <= 32'd0;
`endif
    end else begin
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
`ifdef CP0_BADVADDR_EN
      badvaddr_q <= badvaddr_d;
`endif
    end
  end

  always_comb begin
    data_o = 32'd0;
    case (raddr_i)
`ifdef CP0_BADVADDR_EN
      CP0_REG_BADVADDR: data_o = badvaddr_q;
`endif
      CP0_REG_COUNT:    data_o = count_o;
      CP0_REG_COMPARE:  data_o = compare_o;
      CP0_REG_STATUS:   data_o = status_q;
      CP0_REG_CAUSE:    data_o = cause_q;
      CP0_REG_EPC:      data_o = epc_q;
      CP0_REG_PRID:     data_o = PRID_VALUE;
      CP0_REG_CONFIG:   data_o = CONFIG_VALUE;
      default:          data_o = 32'd0;
    endcase
  end

  assign status_o = status_q;
  assign cause_o  = cause_q;
  assign epc_o    = epc_q;
  assign config_o = CONFIG_VALUE;
  assign prid_o   = PRID_VALUE;

endmodule

`default_nettype wire

// File: tb/tb_cp0_reg.sv
// ============================================================================
// Module      : tb_cp0_reg
// Description : Scoreboard bench for cp0_reg with directed vectors.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cp0_reg;

  localparam logic [31:0] PRID   = 32'h004c_0102;
  localparam logic [31:0] CONFIG = 32'h0000_8000;
  localparam int SEL_DATA = 0, SEL_COUNT = 1, SEL_COMPARE = 2, SEL_STATUS = 3;
  localparam int SEL_CAUSE = 4, SEL_EPC = 5, SEL_CONFIG = 6, SEL_PRID = 7, SEL_TIMER = 8;
  localparam int TIMEOUT_NS = 100000;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] data_i;
  logic [4:0]  raddr_i;
  logic [31:0] data_o;
  logic [5:0]  int_i;
  logic [31:0] except_type_i;
  logic [31:0] current_inst_addr_i;
  logic        is_in_delayslot_i;
`ifdef CP0_BADVADDR_EN
  logic [31:0] bad_addr_i;
`endif
  logic [31:0] count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
  logic        timer_int_o;

  int n_checks = 0;
  int n_errors = 0;

  int          q_sel[$];
  logic [31:0] q_exp[$];
  logic [31:0] q_mask[$];
  string       q_name[$];

  always #5 clk = ~clk;

  cp0_reg dut (
    .clk                 (clk),
    .rst                 (rst),
    .we_i                (we_i),
    .waddr_i             (waddr_i),
    .data_i              (data_i),
    .raddr_i             (raddr_i),
    .data_o              (data_o),
    .int_i               (int_i),
    .except_type_i       (except_type_i),
    .current_inst_addr_i (current_inst_addr_i),
    .is_in_delayslot_i   (is_in_delayslot_i),
`ifdef CP0_BADVADDR_EN
    .bad_addr_i          (bad_addr_i),
`endif
    .count_o             (count_o),
    .compare_o           (compare_o),
    .status_o            (status_o),
    .cause_o             (cause_o),
    .epc_o               (epc_o),
    .config_o            (config_o),
    .prid_o              (prid_o),
    .timer_int_o         (timer_int_o)
  );

  function automatic logic [31:0] get_out(input int sel);
    case (sel)
      SEL_DATA:    return data_o;
      SEL_COUNT:   return count_o;
      SEL_COMPARE: return compare_o;
      SEL_STATUS:  return status_o;
      SEL_CAUSE:   return cause_o;
      SEL_EPC:     return epc_o;
      SEL_CONFIG:  return config_o;
      SEL_PRID:    return prid_o;
      default:     return {31'd0, timer_int_o};
    endcase
  endfunction

  // Monitor: outputs are stable at the falling edge; drain all pending expectations.
  always @(negedge clk) begin
    while (q_sel.size() > 0) begin
      int          sel;
      logic [31:0] exp, mask, act;
      string       nm;
      sel  = q_sel.pop_front();
      exp  = q_exp.pop_front();
      mask = q_mask.pop_front();
      nm   = q_name.pop_front();
      act  = get_out(sel);
      n_checks++;
      if ((act & mask) !== (exp & mask)) begin
        n_errors++;
        $display("FAIL %s: got %h expected %h (mask %h)", nm, act & mask, exp & mask, mask);
      end
    end
  end

  initial begin
    #(TIMEOUT_NS);
    n_errors++;
    $display("FAIL timeout: stimulus did not complete within %0d ns", TIMEOUT_NS);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  task automatic check_now(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic expect_val(input string nm, input int sel, input logic [31:0] exp,
                            input logic [31:0] mask = 32'hFFFF_FFFF);
    q_sel.push_back(sel);
    q_exp.push_back(exp);
    q_mask.push_back(mask);
    q_name.push_back(nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we_i = 1'b0; waddr_i = 5'd0; data_i = 32'd0;
    except_type_i = 32'd0; current_inst_addr_i = 32'd0; is_in_delayslot_i = 1'b0;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; data_i = d;
  endtask

  task automatic except(input logic [31:0] t, input logic [31:0] pc, input logic ds);
    except_type_i = t; current_inst_addr_i = pc; is_in_delayslot_i = ds;
  endtask

  initial begin
    rst = 1'b1; int_i = 6'd0; raddr_i = 5'd15;
`ifdef CP0_BADVADDR_EN
    bad_addr_i = 32'd0;
`endif
    idle_inputs();

    step();
    check_now("rst_status_now", status_o, 32'h1000_0000);
    check_now("rst_count_now", count_o, 32'd0);
    check_now("rst_timer_now", {31'd0, timer_int_o}, 32'd0);
    check_now("rst_prid_now", prid_o, PRID);
    expect_val("rst_status", SEL_STATUS, 32'h1000_0000);
    expect_val("rst_count", SEL_COUNT, 32'd0);
    expect_val("rst_compare", SEL_COMPARE, 32'd0);
    expect_val("rst_timer", SEL_TIMER, 32'd0);
    expect_val("rst_cause", SEL_CAUSE, 32'd0);
    expect_val("rst_epc", SEL_EPC, 32'd0);
    expect_val("rst_prid", SEL_PRID, PRID);
    expect_val("rst_config", SEL_CONFIG, CONFIG);
    expect_val("rst_read_prid", SEL_DATA, PRID);
    settle();

    // Timer: Compare=10, Count=5, then free-run to the match.
    rst = 1'b0;
    write(5'd11, 32'd10);
    step(); expect_val("cmp_write", SEL_COMPARE, 32'd10); expect_val("count_first", SEL_COUNT, 32'd1); settle();
    write(5'd9, 32'd5);
    step(); expect_val("count_load", SEL_COUNT, 32'd5); settle();
    idle_inputs();
    repeat (4) begin step(); settle(); end
    step(); expect_val("count_at_cmp", SEL_COUNT, 32'd10); expect_val("timer_pre", SEL_TIMER, 32'd0); settle();
    step();
    check_now("timer_rise_now", {31'd0, timer_int_o}, 32'd1);
    expect_val("count_after", SEL_COUNT, 32'd11); expect_val("timer_rise", SEL_TIMER, 32'd1); settle();
    step(); expect_val("cause_ip7", SEL_CAUSE, 32'h0000_8000, 32'h0000_8000);
    expect_val("timer_sticky", SEL_TIMER, 32'd1); settle();
    write(5'd11, 32'd0);
    step();
    check_now("timer_clear_now", {31'd0, timer_int_o}, 32'd0);
    expect_val("timer_clear", SEL_TIMER, 32'd0); expect_val("cmp_zero", SEL_COMPARE, 32'd0); settle();

    // Count wrap.
    write(5'd9, 32'hFFFF_FFFE);
    step(); expect_val("count_fffe", SEL_COUNT, 32'hFFFF_FFFE); settle();
    idle_inputs();
    step(); expect_val("count_ffff", SEL_COUNT, 32'hFFFF_FFFF); settle();
    step(); expect_val("count_wrap", SEL_COUNT, 32'd0); settle();

    // Syscall in a delay slot.
    except(32'h08, 32'hBFC0_0100, 1'b1);
    step();
    expect_val("sys_epc", SEL_EPC, 32'hBFC0_00FC);
    expect_val("sys_cause", SEL_CAUSE, 32'h8000_0020);
    expect_val("sys_status", SEL_STATUS, 32'h1000_0002);
    settle();

    // Overflow while EXL=1: EPC and BD held, ExcCode updated.
    except(32'h0c, 32'h0000_0100, 1'b0);
    step();
    expect_val("ov_epc_held", SEL_EPC, 32'hBFC0_00FC);
    expect_val("ov_cause", SEL_CAUSE, 32'h8000_0030);
    expect_val("ov_status", SEL_STATUS, 32'h1000_0002);
    settle();

    except(32'h0e, 32'd0, 1'b0);
    step(); expect_val("eret_status", SEL_STATUS, 32'h1000_0000); expect_val("eret_epc", SEL_EPC, 32'hBFC0_00FC); settle();

    // Status write together with an interrupt exception.
    write(5'd12, 32'hFFFF_FFFF);
    except(32'h01, 32'h0000_0200, 1'b0);
    raddr_i = 5'd14;
    step();
    expect_val("wr_exc_status", SEL_STATUS, 32'hFFFF_FFFF);
    expect_val("wr_exc_epc", SEL_EPC, 32'h0000_0200);
    expect_val("wr_exc_cause", SEL_CAUSE, 32'h0000_0000);
    expect_val("read_epc", SEL_DATA, 32'h0000_0200);
    settle();

    // Cause write: only IP[1:0] sticks, IP2 follows int_i[0].
    idle_inputs();
    write(5'd13, 32'hFFFF_FFFF);
    int_i = 6'b000001; raddr_i = 5'd13;
    step(); expect_val("cause_write", SEL_CAUSE, 32'h0000_0700); expect_val("read_cause", SEL_DATA, 32'h0000_0700); settle();

    // PRId ignores writes; unmapped and Config reads.
    write(5'd15, 32'd0);
    int_i = 6'd0; raddr_i = 5'd15;
    step(); expect_val("prid_ro", SEL_PRID, PRID); expect_val("read_prid2", SEL_DATA, PRID); settle();
    idle_inputs(); raddr_i = 5'd3;
    step(); expect_val("read_unmapped", SEL_DATA, 32'd0); settle();
    raddr_i = 5'd16;
    step(); expect_val("read_config", SEL_DATA, CONFIG); settle();

    except(32'h0e, 32'd0, 1'b0);
    step(); expect_val("eret2_status", SEL_STATUS, 32'hFFFF_FFFD); settle();

    // Address-error load: BadVAddr capture, or ignored when the option is absent.
    except(32'h04, 32'h0000_0300, 1'b0);
    raddr_i = 5'd8;
`ifdef CP0_BADVADDR_EN
    bad_addr_i = 32'h8000_0003;
    step();
    expect_val("badvaddr", SEL_DATA, 32'h8000_0003);
    expect_val("adel_epc", SEL_EPC, 32'h0000_0300);
    expect_val("adel_cause", SEL_CAUSE, 32'h0000_0310);
    expect_val("adel_status", SEL_STATUS, 32'hFFFF_FFFF);
    settle();
`else
    step();
    expect_val("read_addr8", SEL_DATA, 32'd0);
    expect_val("adel_ign_epc", SEL_EPC, 32'h0000_0200);
    expect_val("adel_ign_status", SEL_STATUS, 32'hFFFF_FFFD);
    settle();
`endif

    // Mid-operation reset.
    idle_inputs();
    rst = 1'b1;
    step();
    expect_val("mrst_status", SEL_STATUS, 32'h1000_0000);
    expect_val("mrst_epc", SEL_EPC, 32'd0);
    expect_val("mrst_cause", SEL_CAUSE, 32'd0);
    expect_val("mrst_count", SEL_COUNT, 32'd0);
    expect_val("mrst_timer", SEL_TIMER, 32'd0);
    settle();
    rst = 1'b0;
    settle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
